riscv_fetch_unit: RTL and testbench
===================================

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 SHALL have ports (clock and reset first):
- i_clk  in  1  single clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- o_fetch_imem_req  out  1  instruction-memory request valid
- o_fetch_imem_addr  out  32  request word address
- i_fetch_imem_ack  in  1  request complete, rdata valid this cycle
- i_fetch_imem_rdata  in  32  returned instruction
- i_fetch_stall_f  in  1  hazard-unit fetch stall
- i_fetch_stall_d  in  1  hazard-unit decode stall (hold F/D register)
- i_fetch_flush_d  in  1  hazard-unit decode flush (bubble into F/D)
- i_fetch_redirect  in  1  taken branch/jump resolved in E
- i_fetch_redirect_pc  in  32  redirect target
- o_fetch_instr_d  out  32  F/D instruction
- o_fetch_pc_d  out  32  F/D PC
- o_fetch_pc_plus4_d  out  32  F/D PC+4
- o_fetch_valid_d  out  1  F/D holds a real instruction
- o_fetch_busy  out  1  request outstanding without ack (perf/debug)

Function
REQ-004 SHALL implement FSM states S_REQ (request pending at pc_f), S_HOLD (instruction buffered, request idle), S_KILL (outstanding request to be discarded).
REQ-005 SHALL drive o_fetch_imem_req=1 in S_REQ and S_KILL, 0 in S_HOLD; address SHALL stay stable while req=1 and ack=0.
REQ-006 o_fetch_imem_addr SHALL be pc_f in S_REQ and S_KILL (pc_f frozen in S_KILL).
REQ-007 accept SHALL be !i_fetch_stall_f && !i_fetch_stall_d.
REQ-008 S_REQ, ack, no redirect, accept: rdata->F/D with valid=1, pc_f<=pc_f+4, stay S_REQ.
REQ-009 S_REQ, ack, no redirect, !accept: rdata->hold buffer (instr, pc), go S_HOLD.
REQ-010 S_REQ, no ack, redirect: latch redirect_pc into redir_q, go S_KILL.
REQ-011 S_REQ, ack and redirect same cycle: discard rdata, pc_f<=redirect_pc, stay S_REQ.
REQ-012 S_KILL: redirect overwrites redir_q; on ack discard rdata, pc_f<=redir_q (or redirect_pc if redirect same cycle), go S_REQ.
REQ-013 S_HOLD: redirect drops buffer, pc_f<=redirect_pc, go S_REQ; else if accept, buffer->F/D valid=1, pc_f<=pc_f+4, go S_REQ; else stay.
REQ-014 Redirect SHALL take priority over stall_f/stall_d for pc_f and FSM.
REQ-015 F/D register priority: i_rst > i_fetch_flush_d (bubble) > i_fetch_stall_d (hold) > load.
REQ-016 Load with no instruction delivered this cycle SHALL insert bubble: instr=NOP_INSTR, valid=0, pc/pc_plus4 unchanged.
REQ-017 o_fetch_pc_plus4_d SHALL equal o_fetch_pc_d+4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-018 pc_f+4 SHALL wrap modulo 2^32; bits [1:0] of redirect_pc SHALL be forced to 0.
REQ-019 o_fetch_busy SHALL be (S_REQ or S_KILL) && !ack.
REQ-020 Minimum latency: ack in cycle N with accept -> instruction visible on F/D outputs in N+1.

Reset
REQ-021 On i_rst: state=S_REQ, pc_f=RESET_PC, redir_q=0, hold buffer invalid, o_fetch_instr_d=NOP_INSTR, o_fetch_pc_d=0, o_fetch_pc_plus4_d=4, o_fetch_valid_d=0.
REQ-022 Reset mid-request SHALL abandon it; an ack in the first post-reset cycle belongs to the new RESET_PC request.

Structure
REQ-023 RESET_PC default, NOP_INSTR and FSM state encodings SHALL live in riscv_configs.v.
REQ-024 F/D register SHALL be sub-module riscv_fetch_fd_reg (flush/stall/load priority only); FSM, pc_f, hold buffer in top.

Verification
REQ-025 Reset, ack every cycle, no stalls -> addr 0,4,8; F/D pc 0,4,8 one cycle after each ack, valid=1.
REQ-026 ack at pc 0x10 with stall_f=stall_d=1 for 3 cycles -> req low, F/D held; on release instr of 0x10 enters F/D, next addr 0x14.
REQ-027 redirect to 0x200 while req at 0x20 unacked, ack 2 cycles later -> 0x20 data discarded, busy=1 until ack, next addr 0x200.
REQ-028 ack and redirect to 0x80 same cycle, flush_d=1 -> F/D bubble (NOP, valid=0), next addr 0x80.
REQ-029 flush_d and stall_d both 1 -> bubble wins; redirect_pc 0x103 -> fetch 0x100.
REQ-030 pc_f=0xFFFF_FFFC acked -> F/D pc_plus4=0, next addr 0x0.

Source files
------------

// File: rtl/riscv_configs.sv
// Shared configuration for the RISC-V fetch stage: reset/bubble defaults,
// fetch FSM state encodings, the F/D delivery packet and a PC alignment helper.
package riscv_configs;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Fetch FSM encodings kept as plain constants so older code can reuse them
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  // Instruction handed from the fetch FSM to the F/D register in one cycle
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

  // Instructions are word aligned, so the low two bits of any target are dropped
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_fd_reg.sv
// F/D pipeline register: reset, then flush (bubble), then stall (hold), then load.
// A load with nothing delivered becomes a bubble that keeps the old PC.
module riscv_fetch_fd_reg
  import riscv_configs::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  fetch_pkt_t  load_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcPlus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pcPlus4_q;
  logic        valid_q;

  // Update the F/D contents following the reset > flush > stall > load priority
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= 32'h0000_0000;
      pcPlus4_q <= 32'h0000_0004;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (load_i.valid) begin
        instr_q   <= load_i.instr;
        pc_q      <= load_i.pc;
        pcPlus4_q <= load_i.pc + 32'd4;
        valid_q   <= 1'b1;
      end else begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcPlus4_o = pcPlus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// RISC-V fetch stage: request FSM towards instruction memory, fetch PC,
// one-entry hold buffer for stalled returns, and the F/D register.
module riscv_fetch_unit
  import riscv_configs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_fetch_imem_req,
  output logic [31:0] o_fetch_imem_addr,
  input  logic        i_fetch_imem_ack,
  input  logic [31:0] i_fetch_imem_rdata,
  input  logic        i_fetch_stall_f,
  input  logic        i_fetch_stall_d,
  input  logic        i_fetch_flush_d,
  input  logic        i_fetch_redirect,
  input  logic [31:0] i_fetch_redirect_pc,
  output logic [31:0] o_fetch_instr_d,
  output logic [31:0] o_fetch_pc_d,
  output logic [31:0] o_fetch_pc_plus4_d,
  output logic        o_fetch_valid_d,
  output logic        o_fetch_busy
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pcF_q, pcF_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] holdInstr_q, holdInstr_d;
  logic [31:0] holdPc_q, holdPc_d;
  logic        holdValid_q, holdValid_d;

  logic        accept;
  logic [31:0] redirectPc;
  logic [31:0] pcPlus4F;
  fetch_pkt_t  deliver;

  assign accept     = !i_fetch_stall_f && !i_fetch_stall_d;
  assign redirectPc = alignPc(i_fetch_redirect_pc);
  assign pcPlus4F   = pcF_q + 32'd4;

  assign o_fetch_imem_req  = (state_q != S_HOLD);
  assign o_fetch_imem_addr = pcF_q;
  assign o_fetch_busy      = (state_q != S_HOLD) && !i_fetch_imem_ack;

  // Next-state logic: redirects win over stalls, killed returns are dropped
  always_comb begin
    state_d       = state_q;
    pcF_d         = pcF_q;
    redir_d       = redir_q;
    holdInstr_d   = holdInstr_q;
    holdPc_d      = holdPc_q;
    holdValid_d   = holdValid_q;
    deliver       = '0;
    case (state_q)
      S_REQ: begin
        if (i_fetch_imem_ack) begin
          if (i_fetch_redirect) begin
            pcF_d = redirectPc;
          end else if (accept) begin
            deliver.valid = 1'b1;
            deliver.instr = i_fetch_imem_rdata;
            deliver.pc    = pcF_q;
            pcF_d         = pcPlus4F;
          end else begin
            holdValid_d = 1'b1;
            holdInstr_d = i_fetch_imem_rdata;
            holdPc_d    = pcF_q;
            state_d     = S_HOLD;
          end
        end else if (i_fetch_redirect) begin
          redir_d = redirectPc;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        if (i_fetch_redirect) begin
          redir_d = redirectPc;
        end
        if (i_fetch_imem_ack) begin
          pcF_d   = i_fetch_redirect ? redirectPc : redir_q;
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (i_fetch_redirect) begin
          holdValid_d = 1'b0;
          pcF_d       = redirectPc;
          state_d     = S_REQ;
        end else if (accept) begin
          deliver.valid = 1'b1;
          deliver.instr = holdInstr_q;
          deliver.pc    = holdPc_q;
          holdValid_d   = 1'b0;
          pcF_d         = pcPlus4F;
          state_d       = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Register FSM, fetch PC, pending redirect target and hold buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_REQ;
      pcF_q       <= RESET_PC;
      redir_q     <= 32'h0000_0000;
      holdInstr_q <= NOP_INSTR;
      holdPc_q    <= 32'h0000_0000;
      holdValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcF_q       <= pcF_d;
      redir_q     <= redir_d;
      holdInstr_q <= holdInstr_d;
      holdPc_q    <= holdPc_d;
      holdValid_q <= holdValid_d;
    end
  end

  riscv_fetch_fd_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) uFdReg (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .flush_i   (i_fetch_flush_d),
    .stall_i   (i_fetch_stall_d),
    .load_i    (deliver),
    .instr_o   (o_fetch_instr_d),
    .pc_o      (o_fetch_pc_d),
    .pcPlus4_o (o_fetch_pc_plus4_d),
    .valid_o   (o_fetch_valid_d)
  );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: streaming fetch, stall/hold buffer,
// redirect kill, flush bubbles, alignment, PC wrap and reset mid-request.
module tb_riscv_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        stallF;
  logic        stallD;
  logic        flushD;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic        validD;
  logic        busy;

  int checkCount = 0;
  int errorCount = 0;

  riscv_fetch_unit dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .o_fetch_imem_req    (imemReq),
    .o_fetch_imem_addr   (imemAddr),
    .i_fetch_imem_ack    (imemAck),
    .i_fetch_imem_rdata  (imemRdata),
    .i_fetch_stall_f     (stallF),
    .i_fetch_stall_d     (stallD),
    .i_fetch_flush_d     (flushD),
    .i_fetch_redirect    (redirect),
    .i_fetch_redirect_pc (redirectPc),
    .o_fetch_instr_d     (instrD),
    .o_fetch_pc_d        (pcD),
    .o_fetch_pc_plus4_d  (pcPlus4D),
    .o_fetch_valid_d     (validD),
    .o_fetch_busy        (busy)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the sequence below ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic sF, input logic sD, input logic fD,
                               input logic redir, input logic [31:0] redirPc);
    imemAck    = ack;
    imemRdata  = rdata;
    stallF     = sF;
    stallD     = sD;
    flushD     = fD;
    redirect   = redir;
    redirectPc = redirPc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] streamInstr [3] = '{32'h0A00_0093, 32'h0010_0113, 32'h0020_0193};

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    tick;
    checkOutput("rst_instr",  instrD,   NOP);
    checkOutput("rst_pc",     pcD,      32'h0);
    checkOutput("rst_pc4",    pcPlus4D, 32'h4);
    checkOutput("rst_valid",  {31'b0, validD}, 32'h0);
    checkOutput("rst_req",    {31'b0, imemReq}, 32'h1);
    checkOutput("rst_addr",   imemAddr, 32'h0);
    rst = 1'b0;

    // Back-to-back acks with no stalls
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, streamInstr[i], 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("stream_addr", imemAddr, 32'(i * 4));
      checkOutput("stream_busy", {31'b0, busy}, 32'h0);
      tick;
      checkOutput("stream_pc",    pcD,      32'(i * 4));
      checkOutput("stream_pc4",   pcPlus4D, 32'(i * 4 + 4));
      checkOutput("stream_instr", instrD,   streamInstr[i]);
      checkOutput("stream_valid", {31'b0, validD}, 32'h1);
    end

    // No ack: busy and a bubble that keeps the old PC
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wait_busy", {31'b0, busy}, 32'h1);
    checkOutput("wait_addr", imemAddr, 32'hC);
    tick;
    checkOutput("bubble_valid", {31'b0, validD}, 32'h0);
    checkOutput("bubble_instr", instrD, NOP);
    checkOutput("bubble_pc",    pcD,    32'h8);
    applyStimulus(1'b1, 32'h00C0_0213, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("pc_c", pcD, 32'hC);

    // Ack at 0x10 under full stall for three cycles
    applyStimulus(1'b1, 32'h0042_8293, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("stall_addr", imemAddr, 32'h10);
    tick;
    checkOutput("hold_req",   {31'b0, imemReq}, 32'h0);
    checkOutput("hold_fdpc",  pcD, 32'hC);
    checkOutput("hold_valid", {31'b0, validD}, 32'h1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      tick;
      checkOutput("hold_req_n",  {31'b0, imemReq}, 32'h0);
      checkOutput("hold_fdpc_n", pcD, 32'hC);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("release_instr", instrD, 32'h0042_8293);
    checkOutput("release_pc",    pcD,    32'h10);
    checkOutput("release_valid", {31'b0, validD}, 32'h1);
    checkOutput("release_addr",  imemAddr, 32'h14);

    // Advance to 0x20
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick;
    end

    // Redirect to 0x200 with request at 0x20 unacked, ack two cycles later
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    checkOutput("kill_addr0", imemAddr, 32'h20);
    checkOutput("kill_busy0", {31'b0, busy}, 32'h1);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("kill_req1",  {31'b0, imemReq}, 32'h1);
    checkOutput("kill_addr1", imemAddr, 32'h20);
    checkOutput("kill_busy1", {31'b0, busy}, 32'h1);
    tick;
    applyStimulus(1'b1, 32'hDEAD_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("kill_busy2", {31'b0, busy}, 32'h0);
    tick;
    checkOutput("kill_next",  imemAddr, 32'h200);
    checkOutput("kill_valid", {31'b0, validD}, 32'h0);
    checkOutput("kill_instr", instrD, NOP);

    // Ack with redirect to 0x80 and flush in the same cycle
    applyStimulus(1'b1, 32'h0010_0513, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("pre_flush_pc", pcD, 32'h200);
    applyStimulus(1'b1, 32'hBAD0_0204, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    tick;
    checkOutput("flush_instr", instrD, NOP);
    checkOutput("flush_valid", {31'b0, validD}, 32'h0);
    checkOutput("flush_pc",    pcD, 32'h200);
    checkOutput("flush_pc4",   pcPlus4D, 32'h204);
    checkOutput("flush_addr",  imemAddr, 32'h80);

    // Flush beats stall_d; misaligned redirect is word aligned
    applyStimulus(1'b1, 32'h0020_0593, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("pre_fs_instr", instrD, 32'h0020_0593);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h103);
    tick;
    checkOutput("fs_valid", {31'b0, validD}, 32'h0);
    checkOutput("fs_instr", instrD, NOP);
    checkOutput("fs_pc",    pcD, 32'h80);
    checkOutput("fs_addr",  imemAddr, 32'h84);
    applyStimulus(1'b1, 32'hBAD0_0084, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("align_addr",  imemAddr, 32'h100);
    checkOutput("align_valid", {31'b0, validD}, 32'h0);

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 32'hBAD0_0100, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick;
    checkOutput("wrap_addr", imemAddr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'h0030_0613, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("wrap_pc",    pcD, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4",   pcPlus4D, 32'h0);
    checkOutput("wrap_valid", {31'b0, validD}, 32'h1);
    checkOutput("wrap_next",  imemAddr, 32'h0);

    // Reset while a killed request is outstanding
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("rst2_pc",    pcD, 32'h0);
    checkOutput("rst2_pc4",   pcPlus4D, 32'h4);
    checkOutput("rst2_valid", {31'b0, validD}, 32'h0);
    applyStimulus(1'b1, 32'h0040_0693, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst2_addr", imemAddr, 32'h0);
    tick;
    checkOutput("rst2_instr",  instrD, 32'h0040_0693);
    checkOutput("rst2_valid1", {31'b0, validD}, 32'h1);
    checkOutput("rst2_next",   imemAddr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
